// File: rtl/icdf_coef_fetch.sv
// ICDF front end: segments a uniform word by leading-zero count and fetches the coefficient pair
// for that segment from a 128-entry table loaded after reset. Optional macro: ICDF_SIGN_EN.
module icdf_coef_fetch #(
    parameter int SEG_BITS = 4,
    parameter int SUB_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ld_we,
    input  logic [35:0] ld_data,
    output logic        tbl_ready,
    input  logic        valid_in,
    input  logic [31:0] u_in,
    output logic        valid_out,
    output logic [17:0] coef1,
    output logic [17:0] coef2,
    output logic [14:0] masked_out,
    output logic        sign_out
);
    localparam int ADDR_BITS = SEG_BITS + SUB_BITS;
    localparam int DEPTH     = 1 << ADDR_BITS;

    typedef enum logic {LOAD, RUN} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_BITS-1:0]   r_ld_cnt;
    logic                   w_tbl_we;

    logic [35:0]            r_table [DEPTH];

    logic                   r_s1_valid;
    logic [30:0]            r_s1_u;
    logic [15:0]            w_lz_field;
    logic [SEG_BITS-1:0]    w_lzc;

    logic                   r_s2_valid;
    logic [ADDR_BITS-1:0]   r_s2_addr;
    logic [14:0]            r_s2_masked;

    logic                   r_s3_valid;
    logic [14:0]            r_s3_masked;
    logic [35:0]            r_s3_word;

    logic                   r_valid_out;
    logic [17:0]            r_coef1;
    logic [17:0]            r_coef2;
    logic [14:0]            r_masked_out;

    // Load sequencer: the table fills in address order; RUN is only left through rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD;
            r_ld_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_tbl_we) begin
                r_ld_cnt <= r_ld_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tbl_we     = 1'b0;
        if (r_state == LOAD && ld_we) begin
            w_tbl_we = 1'b1;
            if (&r_ld_cnt) begin
                w_state_next = RUN;
            end
        end
    end

    assign tbl_ready = (r_state == RUN);

    always_ff @(posedge clk) begin
        if (w_tbl_we) begin
            r_table[r_ld_cnt] <= ld_data;
        end
    end

    // S1: words are only accepted once the table is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (en) begin
            r_s1_valid <= valid_in && tbl_ready;
            r_s1_u     <= u_in[30:0];
        end
    end

    // Leading-zero count of u[30:15]; the highest set bit wins, all-zero saturates to 15.
    assign w_lz_field = r_s1_u[30:15];

    always_comb begin
        w_lzc = '1;
        for (int i = 0; i < 16; i++) begin
            if (w_lz_field[i]) begin
                w_lzc = SEG_BITS'(15 - i);
            end
        end
    end

    // S2: table address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else if (en) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_addr   <= {w_lzc, r_s1_u[14 -: SUB_BITS]};
            r_s2_masked <= r_s1_u[14:0];
        end
    end

    // S3: synchronous table read, held with the rest of the pipe when en is low.
    always_ff @(posedge clk) begin
        if (en) begin
            r_s3_word <= r_table[r_s2_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
        end else if (en) begin
            r_s3_valid  <= r_s2_valid;
            r_s3_masked <= r_s2_masked;
        end
    end

    // S4: output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out  <= 1'b0;
            r_coef1      <= '0;
            r_coef2      <= '0;
            r_masked_out <= '0;
        end else if (en) begin
            r_valid_out  <= r_s3_valid;
            r_coef1      <= r_s3_word[17:0];
            r_coef2      <= r_s3_word[35:18];
            r_masked_out <= r_s3_masked;
        end
    end

    assign valid_out  = r_valid_out;
    assign coef1      = r_coef1;
    assign coef2      = r_coef2;
    assign masked_out = r_masked_out;

`ifdef ICDF_SIGN_EN
    logic r_s1_sign;
    logic r_s2_sign;
    logic r_s3_sign;
    logic r_sign_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sign  <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s3_sign  <= 1'b0;
            r_sign_out <= 1'b0;
        end else if (en) begin
            r_s1_sign  <= u_in[31];
            r_s2_sign  <= r_s1_sign;
            r_s3_sign  <= r_s2_sign;
            r_sign_out <= r_s3_sign;
        end
    end

    assign sign_out = r_sign_out;
`else
    // Half-normal build: the sign bit of the input word is deliberately dropped.
    logic w_unused_sign;
    assign w_unused_sign = u_in[31];
    assign sign_out      = 1'b0;
`endif

endmodule

// File: tb/tb_icdf_coef_fetch.sv
// Scoreboard bench for icdf_coef_fetch: table load, directed segments, stalls, mid-stream reset.
module tb_icdf_coef_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ld_we;
    logic [35:0] ld_data;
    logic        tbl_ready;
    logic        valid_in;
    logic [31:0] u_in;
    logic        valid_out;
    logic [17:0] coef1;
    logic [17:0] coef2;
    logic [14:0] masked_out;
    logic        sign_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [51:0] exp_q [$];
    logic [51:0] mon_exp;
    logic [35:0] model_tbl [0:127];
    logic [52:0] snap;
    logic        exp_sign_hi;

    always #5 clk = ~clk;

    icdf_coef_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ld_we      (ld_we),
        .ld_data    (ld_data),
        .tbl_ready  (tbl_ready),
        .valid_in   (valid_in),
        .u_in       (u_in),
        .valid_out  (valid_out),
        .coef1      (coef1),
        .coef2      (coef2),
        .masked_out (masked_out),
        .sign_out   (sign_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference: scan from bit 30 downward, stop after 15 zeros.
    function automatic logic [51:0] model(input logic [31:0] u);
        int          z;
        logic [6:0]  a;
        logic        s;
        z = 0;
        while (z < 15 && !u[30 - z]) z++;
        a = 7'(z * 8 + int'(u[14:12]));
`ifdef ICDF_SIGN_EN
        s = u[31];
`else
        s = 1'b0;
`endif
        return {s, u[14:0], model_tbl[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [31:0] u);
        valid_in = 1'b1;
        u_in     = u;
        if (en && tbl_ready && !rst) exp_q.push_back(model(u));
    endtask

    task automatic load_table();
        for (int i = 0; i < 128; i++) begin
            ld_we   = 1'b1;
            ld_data = model_tbl[i];
            en      = (i % 5 != 3);
            drive_word($urandom);
            tick();
            if (i == 126) begin
                check_eq("tbl_ready_early", 64'(tbl_ready), 64'd0);
                check_eq("load_no_valid", 64'(valid_out), 64'd0);
            end
        end
        ld_we    = 1'b0;
        valid_in = 1'b0;
        en       = 1'b1;
        check_eq("tbl_ready_set", 64'(tbl_ready), 64'd1);
    endtask

    // Consumer: an output counts only on a cycle where en is high.
    always @(negedge clk) begin
        if (!rst && en && valid_out) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 64'(valid_out), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("out_word", 64'({sign_out, masked_out, coef2, coef1}), 64'(mon_exp));
                $display("out u15=%h coef2=%0d coef1=%0d sign=%0d", masked_out, coef2, coef1, sign_out);
            end
        end
    end

    initial begin
`ifdef ICDF_SIGN_EN
        exp_sign_hi = 1'b1;
`else
        exp_sign_hi = 1'b0;
`endif
        for (int i = 0; i < 128; i++) model_tbl[i] = {18'(i), 18'(i + 1000)};
        rst = 1'b1; en = 1'b1; ld_we = 1'b0; ld_data = '0; valid_in = 1'b0; u_in = '0;
        repeat (3) tick();
        check_eq("rst_valid_out", 64'(valid_out), 64'd0);
        check_eq("rst_coef1", 64'(coef1), 64'd0);
        check_eq("rst_coef2", 64'(coef2), 64'd0);
        check_eq("rst_masked", 64'(masked_out), 64'd0);
        check_eq("rst_sign", 64'(sign_out), 64'd0);
        check_eq("rst_tbl_ready", 64'(tbl_ready), 64'd0);
        rst = 1'b0;

        load_table();

        // Latency and directed segment lookup.
        drive_word(32'h8000_5ABC);
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        check_eq("lat_early", 64'(valid_out), 64'd0);
        tick();
        check_eq("lat_valid", 64'(valid_out), 64'd1);
        check_eq("dir_coef2", 64'(coef2), 64'd125);
        check_eq("dir_coef1", 64'(coef1), 64'd1125);
        check_eq("dir_masked", 64'(masked_out), 64'h5ABC);
        check_eq("dir_sign", 64'(sign_out), 64'(exp_sign_hi));
        tick();

        // Segment boundaries, back to back.
        drive_word(32'h4000_0000); tick();
        drive_word(32'h0000_8000); tick();
        drive_word(32'h0001_0000); tick();
        drive_word(32'hFFFF_FFFF); tick();
        drive_word(32'h0000_7FFF); tick();
        drive_word(32'h0000_0000); tick();
        for (int i = 0; i < 6; i++) begin
            drive_word($urandom);
            tick();
        end
        valid_in = 1'b0;
        repeat (5) tick();

        // Two-cycle stall in the middle of a stream.
        for (int c = 0; c < 10; c++) begin
            en = !(c == 5 || c == 6);
            if (c == 5) snap = {valid_out, sign_out, masked_out, coef2, coef1};
            drive_word($urandom);
            tick();
            if (c == 5 || c == 6)
                check_eq("stall_freeze", 64'({valid_out, sign_out, masked_out, coef2, coef1}), 64'(snap));
        end
        en = 1'b1;
        valid_in = 1'b0;
        repeat (6) tick();
        check_eq("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three words in flight, en low to show rst wins.
        drive_word($urandom); tick();
        drive_word($urandom); tick();
        drive_word($urandom); tick();
        rst = 1'b1; en = 1'b0; valid_in = 1'b0;
        exp_q.delete();
        tick();
        check_eq("mid_rst_valid", 64'(valid_out), 64'd0);
        check_eq("mid_rst_coef1", 64'(coef1), 64'd0);
        check_eq("mid_rst_coef2", 64'(coef2), 64'd0);
        check_eq("mid_rst_masked", 64'(masked_out), 64'd0);
        check_eq("mid_rst_sign", 64'(sign_out), 64'd0);
        check_eq("mid_rst_ready", 64'(tbl_ready), 64'd0);
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_word($urandom);
            tick();
        end
        check_eq("unloaded_no_valid", 64'(valid_out), 64'd0);
        load_table();

        // Writes in RUN must not touch the table.
        ld_we = 1'b1; ld_data = 36'hF_FFFF_FFFF;
        tick();
        ld_we = 1'b0;
        drive_word(32'h4000_0000); tick();
        drive_word(32'h8000_5ABC); tick();
        valid_in = 1'b0;
        repeat (2) tick();
        check_eq("run_wr_coef1", 64'(coef1), 64'd1000);
        check_eq("run_wr_coef2", 64'(coef2), 64'd0);
        repeat (6) tick();
        check_eq("final_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
